// File: rtl/pio_capture_in.sv
// Multi-channel input PIO: per-bit synchroniser, warm-up guarded edge capture,
// per-channel interrupt masking and a coherent all-channel snapshot, exposed
// through an Avalon-MM slave with a fixed one-cycle read latency.
module pio_capture_in #(
    parameter int WIDTH       = 32,
    parameter int CHANNELS    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    localparam int ADDR_W     = ($clog2(CHANNELS) + 2 < 2) ? 2 : $clog2(CHANNELS) + 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         address,
    input  logic                      chipselect,
    input  logic                      write,
    input  logic [31:0]               writedata,
    input  logic [CHANNELS*WIDTH-1:0] in_port,
    output logic [31:0]               readdata,
    output logic                      irq
);

    localparam int TOTAL = CHANNELS * WIDTH;
    // prev becomes trustworthy one cycle after the synchroniser has filled
    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    logic [TOTAL-1:0] sync_reg [SYNC_STAGES];
    logic [TOTAL-1:0] prev_reg;
    logic [2:0]       warm_cnt_reg;
    logic             warm_done;
    logic [TOTAL-1:0] sync_out;
    logic [TOTAL-1:0] edge_raw;
    logic [TOTAL-1:0] edge_det;

    logic [31:0]      ch_num;
    logic [1:0]       reg_sel;
    logic             ch_valid;
    logic             wr_en;
    logic             snap_wr;
    logic [31:0]      ch_rd [CHANNELS];
    logic [CHANNELS-1:0] ch_irq;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    assign sync_out  = sync_reg[SYNC_STAGES-1];
    assign warm_done = (warm_cnt_reg == WARM_DONE);

    // Shift every in_port bit through the synchroniser chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    // Track previous synchronised value and count the warm-up window after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_reg     <= '0;
            warm_cnt_reg <= '0;
        end else begin
            prev_reg <= sync_out;
            if (!warm_done) begin
                warm_cnt_reg <= warm_cnt_reg + 3'd1;
            end
        end
    end

    generate
        if (EDGE_MODE == 0) begin : g_rise
            assign edge_raw = sync_out & ~prev_reg;
        end else if (EDGE_MODE == 1) begin : g_fall
            assign edge_raw = ~sync_out & prev_reg;
        end else begin : g_any
            assign edge_raw = sync_out ^ prev_reg;
        end
    endgenerate

    // Edges are ignored until the synchroniser and prev hold real input data
    assign edge_det = warm_done ? edge_raw : '0;

    assign ch_num   = 32'(address >> 2);
    assign reg_sel  = address[1:0];
    assign ch_valid = (ch_num < CHANNELS);
    assign wr_en    = chipselect & write & ch_valid;
    assign snap_wr  = wr_en & (reg_sel == 2'd3);

    // writedata bits above WIDTH carry no meaning
    assign unused_wdata = ^writedata;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] mask_reg;
            logic [WIDTH-1:0] ec_reg;
            logic [WIDTH-1:0] ec_next;
            logic [WIDTH-1:0] snap_reg;
            logic [WIDTH-1:0] ch_sync;
            logic [WIDTH-1:0] ch_edge;
            logic [WIDTH-1:0] w1c_bits;
            logic             sel;

            assign sel      = wr_en && (ch_num == 32'(gi));
            assign ch_sync  = sync_out[gi*WIDTH +: WIDTH];
            assign ch_edge  = edge_det[gi*WIDTH +: WIDTH];
            assign w1c_bits = (sel && reg_sel == 2'd2) ? writedata[WIDTH-1:0] : '0;
            // A new edge overrides a simultaneous clear of the same bit
            assign ec_next  = (ec_reg & ~w1c_bits) | ch_edge;

            // Per-channel mask, sticky edge flags and snapshot latch
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mask_reg <= '0;
                    ec_reg   <= '0;
                    snap_reg <= '0;
                end else begin
                    if (sel && reg_sel == 2'd1) begin
                        mask_reg <= writedata[WIDTH-1:0];
                    end
                    ec_reg <= ec_next;
                    if (snap_wr) begin
                        snap_reg <= ch_sync;
                    end
                end
            end

            assign ch_rd[gi] = (reg_sel == 2'd0) ? 32'(ch_sync)  :
                               (reg_sel == 2'd1) ? 32'(mask_reg) :
                               (reg_sel == 2'd2) ? 32'(ec_reg)   :
                                                   32'(snap_reg);
            assign ch_irq[gi] = |(ec_reg & mask_reg);
        end
    endgenerate

    // Select the addressed channel's word; unmatched channel indices read 0
    always_comb begin
        rd_next = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_num == 32'(c)) begin
                rd_next = ch_rd[c];
            end
        end
    end

    // Reload read data every cycle for a fixed one-cycle latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    assign irq = |ch_irq;

endmodule
